hdlc_wb_frame_checker: RTL and testbench

- Synthesizable, parametrised bus and line checker for the HDLC core; replaces simulation-only byte assertions with hardware counters readable from bench or SoC.
- On each rising edge of the Wishbone ack, checks each byte lane of the read data, one lane per cycle, against a reference byte.
- Also monitors one serial HDLC line for flag (01111110) and abort (≥7 ones) sequences.
- Sits beside the HDLC RX path on the clk_i domain.

---
 rtl/hdlc_wb_frame_checker.sv | 185 ++++++++++++++++++
 tb/tb_hdlc_wb_frame_checker.sv | 317 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hdlc_wb_frame_checker.sv
// Bus/line checker beside the HDLC RX path: compares Wishbone read bytes lane by lane
// against a reference stream and watches one serial line for flag and abort sequences.
module hdlc_wb_frame_checker #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned CNT_W      = 16,
    parameter logic [7:0]  FLAG_PAT   = 8'h7E
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  en_i,
    input  logic                  clr_i,
    input  logic                  ack_i,
    input  logic [DATA_WIDTH-1:0] dat_i,
    input  logic [7:0]            ref_i,
    input  logic                  line_i,
    input  logic                  line_en_i,
    output logic                  busy_o,
    output logic                  done_o,
    output logic                  word_ok_o,
    output logic [CNT_W-1:0]      pass_cnt_o,
    output logic [CNT_W-1:0]      fail_cnt_o,
    output logic                  err_o,
    output logic [2:0]            err_lane_o,
    output logic [7:0]            err_data_o,
    output logic                  retrig_o,
    output logic                  flag_o,
    output logic                  abort_o,
    output logic [CNT_W-1:0]      flag_cnt_o
);

    localparam int unsigned NB     = DATA_WIDTH / 8;
    localparam int unsigned LANE_W = (NB > 1) ? $clog2(NB) : 1;
    localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(NB - 1);

    typedef enum logic {IDLE, CHECK} state_t;

    state_t              state_q, state_d;
    logic                ack_q;
    logic [LANE_W-1:0]   lane_q, lane_d;
    logic                word_bad_q, word_bad_d;
    logic [7:0]          sr_q, sr_d;
    logic [2:0]          run_q, run_d;

    logic                busy_d, done_d, word_ok_d, err_d, retrig_d, flag_d, abort_d;
    logic [CNT_W-1:0]    pass_d, fail_d, flag_cnt_d;
    logic [2:0]          err_lane_d;
    logic [7:0]          err_data_d;
    logic                rise, mism;
    logic [7:0]          lane_byte;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    // Byte of the read data selected by the current lane
    always_comb begin
        lane_byte = '0;
        for (int i = 0; i < NB; i++) begin
            if (lane_q == LANE_W'(i)) lane_byte = dat_i[8*i +: 8];
        end
    end

    assign rise = ack_i & ~ack_q;
    assign mism = (state_q == CHECK) && (lane_byte != ref_i);

    always_comb begin
        state_d    = state_q;
        lane_d     = lane_q;
        word_bad_d = word_bad_q;
        done_d     = 1'b0;
        word_ok_d  = 1'b0;
        pass_d     = pass_cnt_o;
        fail_d     = fail_cnt_o;
        err_d      = err_o;
        err_lane_d = err_lane_o;
        err_data_d = err_data_o;
        retrig_d   = retrig_o;
        sr_d       = sr_q;
        run_d      = run_q;
        flag_d     = 1'b0;
        abort_d    = 1'b0;
        flag_cnt_d = flag_cnt_o;

        case (state_q)
            IDLE: begin
                if (rise && en_i) begin
                    state_d    = CHECK;
                    lane_d     = '0;
                    word_bad_d = 1'b0;
                end
            end
            CHECK: begin
                if (rise) retrig_d = 1'b1;
                if (mism) begin
                    word_bad_d = 1'b1;
                    if (!err_o) begin
                        err_d      = 1'b1;
                        err_lane_d = 3'(lane_q);
                        err_data_d = lane_byte;
                    end
                end
                if (lane_q == LAST_LANE) begin
                    done_d    = 1'b1;
                    word_ok_d = ~(word_bad_q | mism);
                    if (word_ok_d) pass_d = sat_inc(pass_cnt_o);
                    else           fail_d = sat_inc(fail_cnt_o);
                    state_d   = IDLE;
                end else begin
                    lane_d = lane_q + LANE_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase

        // Serial line: shift in on strobe, ones run saturates so abort fires once per run
        if (line_en_i) begin
            sr_d = {sr_q[6:0], line_i};
            if (sr_d == FLAG_PAT) begin
                flag_d     = 1'b1;
                flag_cnt_d = sat_inc(flag_cnt_o);
            end
            if (line_i) begin
                if (run_q != 3'd7) run_d = run_q + 3'd1;
                if (run_q == 3'd6) abort_d = 1'b1;
            end else begin
                run_d = 3'd0;
            end
        end

        if (clr_i) begin
            pass_d     = '0;
            fail_d     = '0;
            flag_cnt_d = '0;
            err_d      = 1'b0;
            err_lane_d = '0;
            err_data_d = '0;
            retrig_d   = 1'b0;
        end

        busy_d = (state_d == CHECK);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= IDLE;
            ack_q      <= 1'b0;
            lane_q     <= '0;
            word_bad_q <= 1'b0;
            sr_q       <= '0;
            run_q      <= '0;
            busy_o     <= 1'b0;
            done_o     <= 1'b0;
            word_ok_o  <= 1'b0;
            pass_cnt_o <= '0;
            fail_cnt_o <= '0;
            err_o      <= 1'b0;
            err_lane_o <= '0;
            err_data_o <= '0;
            retrig_o   <= 1'b0;
            flag_o     <= 1'b0;
            abort_o    <= 1'b0;
            flag_cnt_o <= '0;
        end else begin
            state_q    <= state_d;
            ack_q      <= ack_i;
            lane_q     <= lane_d;
            word_bad_q <= word_bad_d;
            sr_q       <= sr_d;
            run_q      <= run_d;
            busy_o     <= busy_d;
            done_o     <= done_d;
            word_ok_o  <= word_ok_d;
            pass_cnt_o <= pass_d;
            fail_cnt_o <= fail_d;
            err_o      <= err_d;
            err_lane_o <= err_lane_d;
            err_data_o <= err_data_d;
            retrig_o   <= retrig_d;
            flag_o     <= flag_d;
            abort_o    <= abort_d;
            flag_cnt_o <= flag_cnt_d;
        end
    end

endmodule

// File: tb/tb_hdlc_wb_frame_checker.sv
// Bench for hdlc_wb_frame_checker: table-driven words, hand-written corner sequences,
// and randomized words / line bits checked against a transaction-level model.
module tb_hdlc_wb_frame_checker;

    logic        clk = 1'b0;
    logic        rst_i, en_i, clr_i, ack_i, line_i, line_en_i;
    logic [31:0] dat_i;
    logic [7:0]  ref_i, dat8;

    logic        busy_o, done_o, word_ok_o, err_o, retrig_o, flag_o, abort_o;
    logic [15:0] pass_cnt_o, fail_cnt_o, flag_cnt_o;
    logic [2:0]  err_lane_o;
    logic [7:0]  err_data_o;

    logic        busy2, done2, ok2, err2, retrig2, flag2, abort2;
    logic [3:0]  pass2, fail2, flag_cnt2;
    logic [2:0]  err_lane2;
    logic [7:0]  err_data2;

    always #5 clk = ~clk;

    hdlc_wb_frame_checker #(.DATA_WIDTH(32), .CNT_W(16), .FLAG_PAT(8'h7E)) dut (
        .clk_i(clk), .rst_i(rst_i), .en_i(en_i), .clr_i(clr_i), .ack_i(ack_i),
        .dat_i(dat_i), .ref_i(ref_i), .line_i(line_i), .line_en_i(line_en_i),
        .busy_o(busy_o), .done_o(done_o), .word_ok_o(word_ok_o),
        .pass_cnt_o(pass_cnt_o), .fail_cnt_o(fail_cnt_o), .err_o(err_o),
        .err_lane_o(err_lane_o), .err_data_o(err_data_o), .retrig_o(retrig_o),
        .flag_o(flag_o), .abort_o(abort_o), .flag_cnt_o(flag_cnt_o)
    );

    // Single-lane, narrow-counter instance for the NB=1 and saturation corners
    hdlc_wb_frame_checker #(.DATA_WIDTH(8), .CNT_W(4), .FLAG_PAT(8'h7E)) u2 (
        .clk_i(clk), .rst_i(rst_i), .en_i(en_i), .clr_i(clr_i), .ack_i(ack_i),
        .dat_i(dat8), .ref_i(ref_i), .line_i(line_i), .line_en_i(line_en_i),
        .busy_o(busy2), .done_o(done2), .word_ok_o(ok2),
        .pass_cnt_o(pass2), .fail_cnt_o(fail2), .err_o(err2),
        .err_lane_o(err_lane2), .err_data_o(err_data2), .retrig_o(retrig2),
        .flag_o(flag2), .abort_o(abort2), .flag_cnt_o(flag_cnt2)
    );

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model state
    logic [15:0] m_pass, m_fail, m_flags;
    bit          m_err, m_retrig;
    logic [2:0]  m_lane;
    logic [7:0]  m_data;
    bit          hist[$];

    typedef struct {
        logic [31:0] dat;
        logic [31:0] refs;
        bit          en;
        int          clr_lane;
        int          rise_lane;
        bit          ok;
    } vec_t;
    vec_t tbl[8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [15:0] sat16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset;
        m_pass = '0; m_fail = '0; m_flags = '0;
        m_err = 0; m_retrig = 0; m_lane = '0; m_data = '0;
        hist.delete();
    endtask

    task automatic model_clear;
        m_pass = '0; m_fail = '0; m_flags = '0;
        m_err = 0; m_retrig = 0; m_lane = '0; m_data = '0;
    endtask

    task automatic do_reset;
        rst_i = 1; ack_i = 0; en_i = 0; clr_i = 0; line_en_i = 0; line_i = 0;
        dat_i = '0; ref_i = '0; dat8 = '0;
        tick; tick;
        rst_i = 0;
        model_reset();
    endtask

    task automatic chk_state(input string tag);
        chk({tag, "_pass_cnt"}, pass_cnt_o, m_pass);
        chk({tag, "_fail_cnt"}, fail_cnt_o, m_fail);
        chk({tag, "_err"}, err_o, m_err);
        chk({tag, "_err_lane"}, err_lane_o, m_lane);
        chk({tag, "_err_data"}, err_data_o, m_data);
        chk({tag, "_retrig"}, retrig_o, m_retrig);
        chk({tag, "_flag_cnt"}, flag_cnt_o, m_flags);
    endtask

    // One ack rise followed by four lane cycles and one idle cycle
    task automatic do_word(input logic [31:0] dat, input logic [31:0] refs, input bit en,
                           input int clr_lane, input int rise_lane, input bit exp_ok);
        bit bad;
        bit mm;
        bad = 0;
        ack_i = 1; en_i = en; clr_i = 0;
        tick;
        ack_i = 0;
        chk("busy_start", busy_o, en);
        for (int l = 0; l < 4; l++) begin
            dat_i = dat;
            ref_i = refs[8*l +: 8];
            clr_i = (l == clr_lane);
            ack_i = (l == rise_lane);
            en_i  = en ? 1'($urandom_range(0, 1)) : 1'b0;
            mm = (dat[8*l +: 8] != refs[8*l +: 8]);
            tick;
            if (en) begin
                bad = bad | mm;
                if (l == rise_lane) m_retrig = 1;
                if (mm && !m_err) begin
                    m_err = 1; m_lane = 3'(l); m_data = dat[8*l +: 8];
                end
                if (l == 3) begin
                    if (!bad) m_pass = sat16(m_pass);
                    else      m_fail = sat16(m_fail);
                end
            end
            if (l == clr_lane) model_clear();
            if (l < 3) begin
                chk("done_early", done_o, 1'b0);
                chk("busy_mid", busy_o, en);
            end
        end
        chk("done", done_o, en);
        if (en) chk("word_ok", word_ok_o, exp_ok);
        chk("busy_end", busy_o, 1'b0);
        chk_state("word");
        ack_i = 0; clr_i = 0; en_i = 0;
        tick;
        chk("done_pulse", done_o, 1'b0);
        chk("busy_idle", busy_o, 1'b0);
    endtask

    // One line strobe after an idle gap; expectations come from the bit history
    task automatic strobe(input bit b, input int gap, output bit got_f, output bit got_a);
        logic [7:0] last8;
        int run, idx;
        bit ef, ea;
        line_en_i = 0;
        repeat (gap) begin
            tick;
            chk("flag_idle", flag_o, 1'b0);
            chk("abort_idle", abort_o, 1'b0);
        end
        line_en_i = 1; line_i = b;
        tick;
        line_en_i = 0; line_i = 1'($urandom_range(0, 1));
        hist.push_back(b);
        last8 = '0;
        for (int i = 7; i >= 0; i--) begin
            idx = hist.size() - 1 - i;
            last8 = {last8[6:0], (idx >= 0) ? hist[idx] : 1'b0};
        end
        run = 0;
        idx = hist.size() - 1;
        while (idx >= 0 && run < 8 && hist[idx]) begin
            run++;
            idx--;
        end
        ef = (last8 == 8'h7E);
        ea = (run == 7);
        if (ef) m_flags = sat16(m_flags);
        chk("flag", flag_o, ef);
        chk("abort", abort_o, ea);
        got_f = flag_o;
        got_a = abort_o;
    endtask

    initial begin
        logic [31:0] rd, rr;
        int  ln, fidx, aidx, nf, na;
        bit  gf, ga, en_r;
        bit  stream[$];
        logic [7:0] chunk;

        tbl[0] = '{32'h44332211, 32'h44332211, 1'b1, -1, -1, 1'b1};
        tbl[1] = '{32'h44AB2211, 32'h44332211, 1'b1, -1, -1, 1'b0};
        tbl[2] = '{32'h443322FF, 32'h44332211, 1'b1, -1, -1, 1'b0};
        tbl[3] = '{32'h44332211, 32'h44332211, 1'b1, -1,  1, 1'b1};
        tbl[4] = '{32'h4433EE11, 32'h44332211, 1'b1,  0, -1, 1'b0};
        tbl[5] = '{32'h12345678, 32'h12345678, 1'b0, -1, -1, 1'b0};
        tbl[6] = '{32'hA5A5A5A5, 32'hA5A5A5A5, 1'b1, -1,  3, 1'b1};
        tbl[7] = '{32'h44CCDD11, 32'h44332211, 1'b1,  1, -1, 1'b0};

        do_reset();
        chk("rst_busy", busy_o, 1'b0);
        chk("rst_done", done_o, 1'b0);
        chk("rst_ok", word_ok_o, 1'b0);
        chk("rst_pass", pass_cnt_o, 16'h0);
        chk("rst_fail", fail_cnt_o, 16'h0);
        chk("rst_err", err_o, 1'b0);
        chk("rst_lane", err_lane_o, 3'h0);
        chk("rst_data", err_data_o, 8'h0);
        chk("rst_retrig", retrig_o, 1'b0);
        chk("rst_flag", flag_o, 1'b0);
        chk("rst_abort", abort_o, 1'b0);
        chk("rst_flag_cnt", flag_cnt_o, 16'h0);

        foreach (tbl[i]) do_word(tbl[i].dat, tbl[i].refs, tbl[i].en, tbl[i].clr_lane,
                                 tbl[i].rise_lane, tbl[i].ok);
        chk("tbl_final_lane", err_lane_o, 3'd2);
        chk("tbl_final_data", err_data_o, 8'hCC);

        // Clear coincident with the pass increment wins
        do_reset();
        repeat (5) do_word(32'h44332211, 32'h44332211, 1'b1, -1, -1, 1'b1);
        chk("pass_five", pass_cnt_o, 16'd5);
        do_word(32'h44332211, 32'h44332211, 1'b1, 3, -1, 1'b1);
        chk("clr_at_done", pass_cnt_o, 16'd0);
        do_word(32'h01020304, 32'h01020304, 1'b1, -1, -1, 1'b1);
        chk("pass_after_clr", pass_cnt_o, 16'd1);

        // Reset in the middle of a check
        do_reset();
        ack_i = 1; en_i = 1; tick;
        ack_i = 0; dat_i = 32'h44332211; ref_i = 8'h11; tick;
        ref_i = 8'h22; rst_i = 1; tick;
        rst_i = 0;
        model_reset();
        chk("rst_mid_busy", busy_o, 1'b0);
        repeat (6) begin
            tick;
            chk("rst_mid_done", done_o, 1'b0);
            chk("rst_mid_busy_hold", busy_o, 1'b0);
        end
        chk_state("rst_mid");

        // Single-lane instance: two-cycle latency and counter saturation
        do_reset();
        for (int k = 0; k < 20; k++) begin
            ack_i = 1; en_i = 1; tick;
            chk("u2_busy", busy2, 1'b1);
            ack_i = 0; dat8 = 8'(k + 3); ref_i = 8'(k + 3); tick;
            chk("u2_done", done2, 1'b1);
            chk("u2_ok", ok2, 1'b1);
            tick;
            chk("u2_done_pulse", done2, 1'b0);
        end
        chk("u2_sat", pass2, 4'hF);
        chk("u2_fail", fail2, 4'h0);
        chk("u2_err", err2, 1'b0);
        clr_i = 1; tick; clr_i = 0;
        chk("u2_clr", pass2, 4'h0);

        // Randomized words
        do_reset();
        for (int k = 0; k < 60; k++) begin
            rr = $urandom;
            rd = rr;
            if ($urandom_range(0, 2) == 0) begin
                ln = $urandom_range(0, 3);
                rd[8*ln +: 8] = rd[8*ln +: 8] ^ 8'($urandom_range(1, 255));
            end
            en_r = ($urandom_range(0, 4) != 0);
            do_word(rd, rr, en_r,
                    ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 3)) : -1,
                    (en_r && $urandom_range(0, 7) == 0) ? int'($urandom_range(1, 3)) : -1,
                    (rd == rr));
            repeat ($urandom_range(0, 2)) tick;
        end

        // Flag then abort on a strobe every third cycle
        do_reset();
        chunk = 8'h7E;
        fidx = -1; nf = 0;
        for (int i = 0; i < 8; i++) begin
            strobe(chunk[7 - i], 2, gf, ga);
            if (gf) begin nf++; if (fidx < 0) fidx = i + 1; end
        end
        chk("flag_pos", fidx, 8);
        chk("flag_num", nf, 1);
        chk("flag_cnt_one", flag_cnt_o, 16'd1);
        aidx = -1; na = 0;
        for (int i = 0; i < 8; i++) begin
            strobe(1'b1, 2, gf, ga);
            if (ga) begin na++; if (aidx < 0) aidx = i + 1; end
        end
        chk("abort_pos", aidx, 7);
        chk("abort_num", na, 1);

        // Randomized line stream made of flags, noise and long ones runs
        for (int c = 0; c < 40; c++) begin
            case ($urandom_range(0, 2))
                0:       chunk = 8'h7E;
                1:       chunk = 8'($urandom);
                default: chunk = 8'hFF;
            endcase
            for (int i = 7; i >= 0; i--) stream.push_back(chunk[i]);
            if (chunk == 8'hFF) stream.push_back(1'b1);
        end
        foreach (stream[i]) strobe(stream[i], $urandom_range(0, 3), gf, ga);
        chk("rand_flag_cnt", flag_cnt_o, m_flags);
        chk_state("line_end");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
